// File: rtl/ip_csum_scheduler.sv
// Round-robin shared IPv4 header checksum engine: grants one producer at a time,
// sums its header words ones'-complement style and returns the tagged checksum.
module ip_csum_scheduler #(
    parameter int N_REQ     = 2,
    parameter int HDR_WORDS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      s_valid,
    input  logic [32*N_REQ-1:0]   s_data,
    output logic [N_REQ-1:0]      s_ready,
    output logic [N_REQ-1:0]      gnt,
    output logic                  busy,
    output logic [15:0]           csum,
    output logic [1:0]            csum_id,
    output logic                  csum_valid,
    input  logic                  csum_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

    localparam logic [N_REQ-1:0] ONE = 1;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [19:0]       acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       csum_q, csum_d;
    logic [1:0]        csum_id_q, csum_id_d;

    logic [31:0]       word;
    logic              take;
    logic              found;
    int unsigned       cand;
    logic [16:0]       fold1;
    logic [15:0]       fold2;

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) word = word | s_data[32*i +: 32];
        end
    end

    assign take  = (state_q == ACCUM) && (|(s_valid & gnt_q));
    // Two-step end-around carry; the 20-bit sum cannot produce a third carry.
    assign fold1 = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        csum_id_d = csum_id_q;
        found     = 1'b0;
        cand      = 0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    cand = (32'(ptr_q) + k) % N_REQ;
                    if (!found && (|(s_valid & (ONE << cand)))) begin
                        found   = 1'b1;
                        owner_d = 2'(cand);
                        gnt_d   = ONE << cand;
                        ptr_d   = 2'((cand + 1) % N_REQ);
                    end
                end
                if (found) state_d = ACCUM;
            end
            ACCUM: begin
                if (take) begin
                    acc_d = acc_q + {4'b0, word[31:16]} + {4'b0, word[15:0]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(HDR_WORDS - 1)) state_d = FOLD;
                end
            end
            FOLD: begin
                csum_d    = ~fold2;
                csum_id_d = owner_q;
                state_d   = DONE;
            end
            DONE: begin
                if (csum_ready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            csum_id_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            csum_id_q <= csum_id_d;
        end
    end

    assign s_ready    = (state_q == ACCUM) ? gnt_q : '0;
    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign csum       = csum_q;
    assign csum_id    = csum_id_q;
    assign csum_valid = (state_q == DONE);

endmodule

// File: tb/tb_ip_csum_scheduler.sv
// Directed + randomized bench for ip_csum_scheduler; checksums come from a plain
// RFC 1071 fold of each header, results are matched in acceptance order.
module tb_ip_csum_scheduler;

    localparam int N = 2;
    localparam int W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      s_valid;
    logic [32*N-1:0]   s_data;
    logic [N-1:0]      s_ready;
    logic [N-1:0]      gnt;
    logic              busy;
    logic [15:0]       csum;
    logic [1:0]        csum_id;
    logic              csum_valid;
    logic              csum_ready;

    always #5 clk = ~clk;

    ip_csum_scheduler #(.N_REQ(N), .HDR_WORDS(W)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .gnt(gnt), .busy(busy), .csum(csum),
        .csum_id(csum_id), .csum_valid(csum_valid), .csum_ready(csum_ready)
    );

    typedef struct packed { logic [1:0] id; logic [15:0] cs; } res_t;

    int errors = 0;
    int checks = 0;

    logic [31:0] std_hdr [W];
    logic [31:0] hdr [N][W];
    int  hdr_mode [N];
    int  widx [N];
    int  left [N];
    int  stall_at [N];
    int  stall_len [N];
    bit  rand_stall;
    int  rdy_mode;
    int  hold_left;
    res_t exp_q [$];
    int  gnt_log [$];
    logic [N-1:0] prev_gnt;
    int  cyc;
    bit  waiting;
    logic [15:0] held_cs;
    logic [1:0]  held_id;
    bit  armed;
    int  req_cyc, gnt_cyc, val_cyc, val_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_csum(input logic [31:0] w [W]);
        logic [31:0] s = 0;
        for (int i = 0; i < W; i++) s += {16'h0, w[i][31:16]} + {16'h0, w[i][15:0]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic load(input int i, input int mode);
        hdr_mode[i] = mode;
        for (int w = 0; w < W; w++) begin
            case (mode)
                0: hdr[i][w] = std_hdr[w];
                1: hdr[i][w] = 32'h0000_0000;
                2: hdr[i][w] = 32'hFFFF_FFFF;
                default: hdr[i][w] = $urandom;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            chk("sready_only_owner", 32'(s_ready & ~gnt), 0);
        end
    end

    task automatic cycle();
        logic [N-1:0] acc;
        bit v;
        res_t e;
        int gi;
        for (int i = 0; i < N; i++) begin
            v = left[i] > 0;
            if (v && widx[i] == stall_at[i] && stall_len[i] > 0) begin
                v = 1'b0;
                stall_len[i]--;
            end
            if (v && rand_stall && $urandom_range(3) == 0) v = 1'b0;
            s_valid[i] = v;
            s_data[32*i +: 32] = hdr[i][widx[i]];
        end
        case (rdy_mode)
            0: csum_ready = 1'b1;
            1: csum_ready = 1'($urandom_range(1));
            default: begin
                if (csum_valid && hold_left > 0) begin
                    csum_ready = 1'b0;
                    hold_left--;
                end else csum_ready = 1'b1;
            end
        endcase
        #1;
        acc = s_valid & s_ready;
        if (armed && (|s_valid) && !busy && req_cyc < 0) req_cyc = cyc;
        if (waiting) begin
            chk("hold_valid", 32'(csum_valid), 1);
            chk("hold_csum", 32'(csum), 32'(held_cs));
            chk("hold_id", 32'(csum_id), 32'(held_id));
        end
        if (csum_valid && csum_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("csum_id", 32'(csum_id), 32'(e.id));
                chk("csum", 32'(csum), 32'(e.cs));
            end
        end
        waiting = csum_valid && !csum_ready;
        held_cs = csum;
        held_id = csum_id;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (widx[i] == W - 1) begin
                    exp_q.push_back('{id: 2'(i), cs: ref_csum(hdr[i])});
                    widx[i] = 0;
                    left[i]--;
                    if (left[i] > 0) load(i, hdr_mode[i]);
                end else widx[i]++;
            end
        end
        if (gnt != '0 && prev_gnt == '0) begin
            gi = -1;
            for (int j = 0; j < N; j++) if (gnt[j]) gi = j;
            gnt_log.push_back(gi);
        end
        prev_gnt = gnt;
        if (armed && gnt != '0 && gnt_cyc < 0) gnt_cyc = cyc;
        if (armed && csum_valid && val_cyc < 0) val_cyc = cyc;
        if (armed && csum_valid) val_len++;
    endtask

    task automatic run(input int budget, input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0 || left[0] != 0 || left[1] != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_completed"}, 32'(n < budget), 1);
    endtask

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            widx[i] = 0; left[i] = 0; stall_at[i] = -1; stall_len[i] = 0;
        end
        exp_q.delete();
        gnt_log.delete();
        prev_gnt = '0;
        waiting = 1'b0;
        s_valid = '0;
        s_data = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_csum"}, 32'(csum), 0);
        chk({tag, "_csum_id"}, 32'(csum_id), 0);
        chk({tag, "_csum_valid"}, 32'(csum_valid), 0);
    endtask

    initial begin
        int n;
        std_hdr = '{32'h45000073, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
        cyc = 0; armed = 0; rand_stall = 0; rdy_mode = 0; hold_left = 0;
        req_cyc = -1; gnt_cyc = -1; val_cyc = -1; val_len = 0;
        csum_ready = 1'b0;
        for (int i = 0; i < N; i++) load(i, 0);
        clear_tb();

        // Reset values
        #1 reset = 1'b1;
        #2;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cycle();
        check_zero_outputs("post_reset_idle");

        // Single header, latency and one-cycle valid
        load(0, 0); left[0] = 1; rdy_mode = 0;
        armed = 1; req_cyc = -1; gnt_cyc = -1; val_cyc = -1; val_len = 0;
        run(40, "single");
        armed = 0;
        chk("single_csum_value", 32'(csum), 32'hB861);
        chk("single_csum_id", 32'(csum_id), 0);
        chk("single_grant_latency", 32'(gnt_cyc - req_cyc), 1);
        chk("single_valid_latency", 32'(val_cyc - req_cyc), 7);
        chk("single_valid_len", 32'(val_len), 1);

        // Boundary data patterns
        load(1, 1); left[1] = 1;
        run(40, "zeros");
        chk("zeros_csum", 32'(csum), 32'hFFFF);
        chk("zeros_id", 32'(csum_id), 1);
        load(0, 2); left[0] = 1;
        run(40, "ones");
        chk("ones_csum", 32'(csum), 32'h0000);

        // Contention from reset: strict alternation
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        clear_tb();
        load(0, 0); load(1, 0); left[0] = 3; left[1] = 3;
        run(200, "contention");
        chk("contention_grants", 32'(gnt_log.size()), 6);
        for (int k = 0; k < gnt_log.size() && k < 6; k++)
            chk($sformatf("contention_order%0d", k), 32'(gnt_log[k]), 32'(k % 2));

        // Owner stall after word 2 and consumer back-pressure in DONE
        gnt_log.delete();
        load(0, 0); load(1, 0); left[0] = 1; left[1] = 1;
        stall_at[0] = 3; stall_len[0] = 3; rdy_mode = 2; hold_left = 4;
        run(80, "stall");
        chk("stall_stalled", 32'(stall_len[0]), 0);
        chk("stall_held", 32'(hold_left), 0);
        chk("stall_first_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 0);
        chk("stall_csum", 32'(csum), 32'hB861);
        stall_at[0] = -1; rdy_mode = 0;

        // Asynchronous reset in ACCUM after word 3
        gnt_log.delete();
        load(0, 0); left[0] = 1;
        n = 0;
        while (widx[0] != 4 && n < 20) begin
            cycle();
            n++;
        end
        chk("rst_reached_word3", 32'(widx[0]), 4);
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        clear_tb();
        load(0, 0); load(1, 0); left[0] = 1; left[1] = 1;
        run(80, "after_reset");
        chk("after_reset_first_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 0);
        chk("after_reset_grants", 32'(gnt_log.size()), 2);

        // Randomized data, owner stalls and result back-pressure
        load(0, 3); load(1, 3); left[0] = 8; left[1] = 8;
        rand_stall = 1; rdy_mode = 1;
        run(3000, "random");
        rand_stall = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
